// File: rtl/tcbm_device_engine.sv
// tcbm_device_engine
//   Drive-side TCBM protocol engine. It sits directly behind the emulated
//   6523 port pins. It runs the 4-phase DAV/ACK handshake with the host and
//   decodes the code byte. It then moves one data byte between the host and
//   the MCU side over valid/ready byte streams.
//
// Ports
//   clock      : system clock; all logic is posedge
//   _reset     : asynchronous active-low reset
//   pa_in      : PA pins as seen by the device
//   pa_out     : PA value driven by the device
//   pa_oe      : 1 = device drives PA
//   dav_in     : host DAV strobe (PC7), active-low, asynchronous
//   ack_out    : device ACK (PC6), active-low
//   st_out     : status to host on PB[1:0]
//   rx_data    : byte received from the host
//   rx_is_cmd  : rx byte came from a command (0x81) transaction
//   rx_valid   : rx byte available
//   rx_ready   : MCU accepts the rx byte
//   tx_data    : byte for the host
//   tx_eoi     : tx_data is the last byte
//   tx_valid   : tx byte offered
//   tx_ready   : engine takes the tx byte (held high while fetching)
//
// All outputs are registered, so no input reaches an output combinationally.
module tcbm_device_engine #(
  parameter int TIMEOUT = 50000,
  parameter int TO_BITS = 16
) (
  input  logic       clock,
  input  logic       _reset,
  input  logic [7:0] pa_in,
  output logic [7:0] pa_out,
  output logic       pa_oe,
  input  logic       dav_in,
  output logic       ack_out,
  output logic [1:0] st_out,
  output logic [7:0] rx_data,
  output logic       rx_is_cmd,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_eoi,
  input  logic       tx_valid,
  output logic       tx_ready
);

  typedef enum logic [2:0] {
    IDLE,
    CODE_HOLD,
    DATA_WAIT,
    RX_DELIVER,
    TX_FETCH,
    TX_SETUP,
    DATA_HOLD
  } state_t;

  localparam logic [7:0] CODE_CMD = 8'h81;
  localparam logic [7:0] CODE_WR  = 8'h82;
  localparam logic [7:0] CODE_RD  = 8'h83;

  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ERR_EOI = 2'b11;

  state_t             state, state_nx;
  logic [7:0]         code, code_nx;
  logic [TO_BITS-1:0] cnt, cnt_nx;
  logic               dav_meta, dav_s;

  logic [7:0]         pa_out_nx;
  logic               pa_oe_nx;
  logic               ack_nx;
  logic [1:0]         st_nx;
  logic [7:0]         rx_data_nx;
  logic               rx_is_cmd_nx;
  logic               rx_valid_nx;
  logic               tx_ready_nx;

  function automatic logic is_valid_code(input logic [7:0] c);
    return (c == CODE_CMD) || (c == CODE_WR) || (c == CODE_RD);
  endfunction

  // DAV synchronizer; the rest of the engine only ever looks at dav_s.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      dav_meta <= 1'b1;
      dav_s    <= 1'b1;
    end else begin
      dav_meta <= dav_in;
      dav_s    <= dav_meta;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      state     <= IDLE;
      code      <= 8'h00;
      cnt       <= '0;
      pa_out    <= 8'h00;
      pa_oe     <= 1'b0;
      ack_out   <= 1'b1;
      st_out    <= ST_OK;
      rx_data   <= 8'h00;
      rx_is_cmd <= 1'b0;
      rx_valid  <= 1'b0;
      tx_ready  <= 1'b0;
    end else begin
      state     <= state_nx;
      code      <= code_nx;
      cnt       <= cnt_nx;
      pa_out    <= pa_out_nx;
      pa_oe     <= pa_oe_nx;
      ack_out   <= ack_nx;
      st_out    <= st_nx;
      rx_data   <= rx_data_nx;
      rx_is_cmd <= rx_is_cmd_nx;
      rx_valid  <= rx_valid_nx;
      tx_ready  <= tx_ready_nx;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx     = state;
    code_nx      = code;
    pa_out_nx    = pa_out;
    pa_oe_nx     = pa_oe;
    ack_nx       = ack_out;
    st_nx        = st_out;
    rx_data_nx   = rx_data;
    rx_is_cmd_nx = rx_is_cmd;
    rx_valid_nx  = rx_valid;

    case (state)
      IDLE: begin
        if (!dav_s) begin
          code_nx  = pa_in;
          ack_nx   = 1'b0;
          st_nx    = is_valid_code(pa_in) ? ST_OK : ST_ERR_EOI;
          state_nx = CODE_HOLD;
        end
      end
      CODE_HOLD: begin
        if (dav_s) begin
          ack_nx   = 1'b1;
          state_nx = is_valid_code(code) ? DATA_WAIT : IDLE;
        end
      end
      DATA_WAIT: begin
        if (!dav_s) begin
          if (code == CODE_RD) begin
            state_nx = TX_FETCH;
          end else begin
            rx_data_nx   = pa_in;
            rx_is_cmd_nx = (code == CODE_CMD);
            rx_valid_nx  = 1'b1;
            state_nx     = RX_DELIVER;
          end
        end
      end
      RX_DELIVER: begin
        // ACK is withheld until the MCU has taken the byte.
        if (rx_ready) begin
          rx_valid_nx = 1'b0;
          ack_nx      = 1'b0;
          state_nx    = DATA_HOLD;
        end
      end
      TX_FETCH: begin
        if (tx_valid && tx_ready) begin
          pa_out_nx = tx_data;
          pa_oe_nx  = 1'b1;
          st_nx     = tx_eoi ? ST_ERR_EOI : ST_OK;
          state_nx  = TX_SETUP;
        end
      end
      TX_SETUP: begin
        // PA has been driven for one full cycle before ACK falls.
        ack_nx   = 1'b0;
        state_nx = DATA_HOLD;
      end
      DATA_HOLD: begin
        if (dav_s) begin
          ack_nx   = 1'b1;
          pa_oe_nx = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Abort only when no regular exit fires this cycle; a real exit wins.
    if ((state != IDLE) && (state_nx == state) && (cnt == TO_LAST)) begin
      state_nx    = IDLE;
      ack_nx      = 1'b1;
      pa_oe_nx    = 1'b0;
      rx_valid_nx = 1'b0;
      st_nx       = ST_TIMEOUT;
    end

    // Registered, so tx_ready drops the cycle after the single handshake.
    tx_ready_nx = (state_nx == TX_FETCH);

    cnt_nx = ((state == IDLE) || (state_nx != state)) ? '0 : cnt + TO_BITS'(1);
  end

endmodule

// File: tb/tb_tcbm_device_engine.sv
module tb_tcbm_device_engine;

  logic       clock = 1'b0;
  logic       rst_main, rst_to;
  logic [7:0] pa;
  logic       dav;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_eoi, tx_valid;

  // Main instance (default timeout)
  logic [7:0] pa_out1, rx_data1;
  logic       pa_oe1, ack1, rx_is_cmd1, rx_valid1, tx_ready1;
  logic [1:0] st1;
  // Short-timeout instance
  logic [7:0] pa_out2, rx_data2;
  logic       pa_oe2, ack2, rx_is_cmd2, rx_valid2, tx_ready2;
  logic [1:0] st2;

  int total = 0;
  int bad   = 0;
  int rxv_cnt = 0, txr_cnt = 0, txhs_cnt = 0;

  always #5 clock = ~clock;

  tcbm_device_engine dut (
    .clock(clock), ._reset(rst_main), .pa_in(pa), .pa_out(pa_out1), .pa_oe(pa_oe1),
    .dav_in(dav), .ack_out(ack1), .st_out(st1), .rx_data(rx_data1),
    .rx_is_cmd(rx_is_cmd1), .rx_valid(rx_valid1), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_eoi(tx_eoi), .tx_valid(tx_valid), .tx_ready(tx_ready1)
  );

  tcbm_device_engine #(.TIMEOUT(64), .TO_BITS(16)) dut_to (
    .clock(clock), ._reset(rst_to), .pa_in(pa), .pa_out(pa_out2), .pa_oe(pa_oe2),
    .dav_in(dav), .ack_out(ack2), .st_out(st2), .rx_data(rx_data2),
    .rx_is_cmd(rx_is_cmd2), .rx_valid(rx_valid2), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_eoi(tx_eoi), .tx_valid(tx_valid), .tx_ready(tx_ready2)
  );

  always @(negedge clock) begin
    if (rx_valid1) rxv_cnt = rxv_cnt + 1;
    if (tx_ready1) txr_cnt = txr_cnt + 1;
    if (tx_valid && tx_ready1) txhs_cnt = txhs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input bit inst, input logic lvl, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clock); #1;
      if ((inst ? ack2 : ack1) == lvl) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_txrdy(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clock); #1;
      if (tx_ready1) begin
        n = i;
        break;
      end
    end
  endtask

  // Full 4-phase exchange of one byte; ACK must fall within 4 edges of DAV fall.
  task automatic host_byte(input bit inst, input logic [7:0] v, input string tag);
    int n;
    pa = v; dav = 1'b0;
    wait_ack(inst, 1'b0, 20, n);
    chk({tag, " ack_lo_lat"}, (n >= 1 && n <= 4), 1);
    dav = 1'b1;
    wait_ack(inst, 1'b1, 20, n);
    chk({tag, " ack_hi"}, (n > 0), 1);
  endtask

  task automatic do_read(input logic [7:0] d, input logic eoi, input int dly, input string tag);
    int n, hs0;
    tx_data = d; tx_eoi = eoi; tx_valid = 1'b0;
    host_byte(0, 8'h83, {tag, " code"});
    hs0 = txhs_cnt;
    pa = 8'h00; dav = 1'b0;
    wait_txrdy(10, n);
    chk({tag, " txrdy"}, (n > 0), 1);
    repeat (dly) @(posedge clock);
    #1;
    chk({tag, " wait ack/oe/rdy"}, {ack1, pa_oe1, tx_ready1}, 3'b101);
    tx_valid = 1'b1;
    @(posedge clock); #1;
    tx_valid = 1'b0;
    chk({tag, " setup oe/ack/rdy"}, {pa_oe1, ack1, tx_ready1}, 3'b110);
    chk({tag, " pa_out"}, pa_out1, d);
    @(posedge clock); #1;
    chk({tag, " ack after setup"}, {pa_oe1, ack1}, 2'b10);
    chk({tag, " st"}, st1, eoi ? 2'b11 : 2'b00);
    dav = 1'b1;
    wait_ack(0, 1'b1, 20, n);
    chk({tag, " release"}, (n > 0), 1);
    chk({tag, " oe off"}, pa_oe1, 1'b0);
    chk({tag, " st hold"}, st1, eoi ? 2'b11 : 2'b00);
    chk({tag, " one hs"}, txhs_cnt - hs0, 1);
  endtask

  initial begin
    int n, r0, t0, ok;
    rst_main = 1'b0; rst_to = 1'b0;
    pa = 8'h00; dav = 1'b1; rx_ready = 1'b1;
    tx_data = 8'h00; tx_eoi = 1'b0; tx_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset ctl", {ack1, pa_oe1, st1, rx_valid1, rx_is_cmd1, tx_ready1}, 7'b1000000);
    chk("reset data", {pa_out1, rx_data1}, 16'h0000);
    rst_main = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Write data 0x82 / 0xA5
    r0 = rxv_cnt;
    host_byte(0, 8'h82, "wr code");
    chk("wr code st", st1, 2'b00);
    host_byte(0, 8'hA5, "wr data");
    chk("wr rx_data", rx_data1, 8'hA5);
    chk("wr is_cmd", rx_is_cmd1, 1'b0);
    chk("wr one pulse", rxv_cnt - r0, 1);
    chk("wr st/oe", {st1, pa_oe1}, 3'b000);

    // Invalid code 0x55
    r0 = rxv_cnt; t0 = txr_cnt;
    host_byte(0, 8'h55, "inv");
    chk("inv st", st1, 2'b11);
    chk("inv no rx/tx", {rxv_cnt - r0, txr_cnt - t0}, 64'd0);

    // Command 0x81 / 0x3C with back-pressure
    rx_ready = 1'b0;
    host_byte(0, 8'h81, "cmd code");
    chk("cmd code st", st1, 2'b00);
    pa = 8'h3C; dav = 1'b0;
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clock); #1;
      if (rx_valid1) begin n = i; break; end
    end
    chk("cmd rx_valid", (n > 0), 1);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (ack1 && rx_valid1 && rx_data1 == 8'h3C) ok++;
      @(posedge clock); #1;
    end
    chk("cmd hold", ok, 100);
    rx_ready = 1'b1;
    @(posedge clock); #1;
    chk("cmd accept", {ack1, rx_valid1}, 2'b00);
    chk("cmd is_cmd", rx_is_cmd1, 1'b1);
    chk("cmd rx_data", rx_data1, 8'h3C);
    dav = 1'b1;
    wait_ack(0, 1'b1, 20, n);
    chk("cmd release", (n > 0), 1);

    // Read 0x83 returning 0x7E with EOI after 20 cycles
    do_read(8'h7E, 1'b1, 20, "rd");

    // Timeout on the TIMEOUT=64 instance
    rst_main = 1'b0; rst_to = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("to reset", {ack2, pa_oe2, st2, rx_valid2, tx_ready2}, 6'b100000);
    host_byte(1, 8'h82, "to code");
    repeat (63) @(posedge clock);
    #1;
    chk("to not yet", {st2, ack2}, 3'b001);
    @(posedge clock); #1;
    chk("to fired", {st2, ack2, pa_oe2, rx_valid2}, 5'b01100);
    host_byte(1, 8'h82, "to2 code");
    host_byte(1, 8'h11, "to2 data");
    chk("to2 rx_data", rx_data2, 8'h11);
    chk("to2 st", st2, 2'b00);

    // Async reset in the middle of a read
    rst_to = 1'b0; rst_main = 1'b1;
    @(posedge clock); #1;
    tx_data = 8'h5A; tx_eoi = 1'b1;
    host_byte(0, 8'h83, "ar code");
    pa = 8'h00; dav = 1'b0;
    wait_txrdy(10, n);
    chk("ar txrdy", (n > 0), 1);
    tx_valid = 1'b1;
    @(posedge clock); #1;
    tx_valid = 1'b0;
    @(posedge clock); #1;
    chk("ar mid", {pa_oe1, ack1, st1}, 4'b1011);
    #2 rst_main = 1'b0;
    #1;
    chk("ar async ctl", {ack1, pa_oe1, st1, rx_valid1, rx_is_cmd1, tx_ready1}, 7'b1000000);
    chk("ar async pa", pa_out1, 8'h00);
    dav = 1'b1;
    repeat (3) @(posedge clock);
    #1 rst_main = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    do_read(8'hC3, 1'b0, 2, "rd2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tcbm_device_engine.md
Name: tcbm_device_engine

Overview:
- Drive-side TCBM protocol engine; the stage directly downstream of the fake 6523 port pins (PA data, PB status, PC handshake).
- Runs the 4-phase DAV/ACK handshake, decodes a code byte, then moves one data byte between the host and the SD/MCU side through valid/ready byte streams.
- Pins are split into in/out/oe. The top level merges them onto the inout ports.

Parameters:
- TIMEOUT, 50000, clock cycles allowed in any non-IDLE state before the transaction is aborted.
- TO_BITS, 16, width of the timeout counter. It must hold TIMEOUT-1.

Ports:
- clock, in, 1: single system clock; everything is posedge.
- _reset, in, 1: asynchronous, active-low reset.
- pa_in, in, 8: PA pins as seen by the device.
- pa_out, out, 8: PA value driven by the device.
- pa_oe, out, 1: 1 = device drives PA.
- dav_in, in, 1: host DAV strobe (PC7), active-low, asynchronous to clock.
- ack_out, out, 1: device ACK (PC6), active-low.
- st_out, out, 2: status to host on PB[1:0].
- rx_data, out, 8: byte received from the host.
- rx_is_cmd, out, 1: 1 = rx byte came from a command (0x81) transaction.
- rx_valid, out, 1: rx byte available.
- rx_ready, in, 1: MCU accepts the rx byte.
- tx_data, in, 8: byte for the host.
- tx_eoi, in, 1: marks tx_data as the last byte.
- tx_valid, in, 1: tx byte offered.
- tx_ready, out, 1: engine takes the tx byte.

Behaviour:
- DAV input: passes through a 2-flop synchronizer and is used only as dav_s. Every DAV edge therefore has 2 cycles of latency.
- Reset (async, any time including mid-transfer) forces:
  - ack_out=1, pa_oe=0, pa_out=0, st_out=00
  - rx_valid=0, rx_is_cmd=0, tx_ready=0, rx_data=0
  - state=IDLE, counter=0, dav sync flops=1
- Code bytes:
  - 0x81: command byte to device.
  - 0x82: data byte to device.
  - 0x83: data byte from device.
  - Any other value is invalid.
- IDLE: on dav_s==0, latch pa_in as code, set ack_out=0, go CODE_HOLD.
  - On a valid code, clear st_out to 00.
  - On an invalid code, set st_out=11.
- CODE_HOLD: on dav_s==1, set ack_out=1. Invalid code goes to IDLE; valid code goes to DATA_WAIT.
- DATA_WAIT: on dav_s==0:
  - Code 0x81/0x82: latch pa_in into rx_data, set rx_is_cmd=(code==0x81), set rx_valid=1, go RX_DELIVER.
  - Code 0x83: go TX_FETCH.
- RX_DELIVER: hold rx_valid=1 and rx_data stable until rx_ready==1. In the accept cycle, rx_valid goes 0 and ack_out goes 0 on the next edge; go DATA_HOLD.
  - ACK is never asserted before the MCU has taken the byte. This is the back-pressure path.
- TX_FETCH: tx_ready=1 while in this state.
  - On tx_valid&tx_ready: register pa_out=tx_data, pa_oe=1, st_out=(tx_eoi ? 11 : 00), go TX_SETUP.
  - tx_ready drops the cycle after the handshake, so exactly one byte is consumed.
- TX_SETUP: one cycle of data setup, then ack_out=0, go DATA_HOLD.
- DATA_HOLD: on dav_s==1, set ack_out=1 and pa_oe=0, go IDLE. st_out holds until the next code latch.
- Timeout counter:
  - Clears on every state change and runs in all states except IDLE.
  - When it reaches TIMEOUT-1 with no transition: go IDLE, ack_out=1, pa_oe=0, rx_valid=0, tx_ready=0, st_out=01.
  - An rx byte pending at timeout is dropped.
- Simultaneous events: a state's exit condition and the timeout in the same cycle → the exit condition wins and the counter clears.
- A DAV glitch shorter than 1 cycle may be missed; the host-side protocol guarantees DAV levels are held well beyond 2 cycles.
- ack_out, pa_out, pa_oe, st_out, rx_*, tx_ready are all registered; no combinational path from any input to any output.

Test Plan:
- Write data: host code 0x82, then data 0xA5 with full DAV/ACK 4-phase, rx_ready=1 → rx_data=0xA5, rx_is_cmd=0, one rx_valid pulse; ack_out low within 4 cycles of each DAV fall; st_out=00.
- Command with back-pressure: code 0x81, data 0x3C, rx_ready held 0 for 100 cycles → ack_out stays 1 and rx_valid=1 for the whole hold; rx_ready=1 → ack_out=0 next edge; rx_is_cmd=1.
- Read: code 0x83, tx_data=0x7E with tx_eoi=1 presented after 20 cycles → pa_oe=1 and pa_out=0x7E at least 1 cycle before ack_out=0; st_out=11; after DAV rise, pa_oe=0 and ack_out=1; exactly one tx handshake.
- Invalid code 0x55 → ack_out low/high handshake completes, st_out=11, engine back in IDLE, no rx_valid or tx_ready activity.
- Timeout: TIMEOUT=64, code 0x82 then DAV held high forever → after 64 cycles in DATA_WAIT the engine returns to IDLE, st_out=01, ack_out=1; the next code 0x82 transfer succeeds and restores st_out=00.
- Async reset mid-read (pa_oe=1, ack_out=0) → outputs take reset values immediately without a clock edge; a subsequent full read transaction works.
